// File: rtl/conv_idx_pkg.sv
// Shared types and geometry helpers for the convolution window index generator.
// The sweep FSM state and output-dimension arithmetic live here.
package conv_idx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int out_dim(
        input int img,
        input int k,
        input int pad,
        input int stride
    );
        return (img + 2 * pad - k) / stride + 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/idx_wrap_counter.sv
// Modulo (MAX+1) up-counter; wrap flags the increment that returns it to 0
// and serves as the carry into the next counter of a chain.
module idx_wrap_counter #(
    parameter int MAX   = 0,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    assign wrap = inc && (cnt == WIDTH'(MAX));

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/conv_window_index_gen.sv
// Sweeps a strided, zero-padded 2-D convolution and emits one registered
// index tuple per valid/ready transfer.
module conv_window_index_gen
    import conv_idx_pkg::*;
#(
    parameter int IMG_ROWS  = 4,
    parameter int IMG_COLS  = 4,
    parameter int K_ROWS    = 3,
    parameter int K_COLS    = 3,
    parameter int STRIDE    = 1,
    parameter int PAD       = 0,
    parameter int WIDTH_BIT = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 clear,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [WIDTH_BIT-1:0] out_row,
    output logic [WIDTH_BIT-1:0] out_col,
    output logic [WIDTH_BIT-1:0] k_row,
    output logic [WIDTH_BIT-1:0] k_col,
    output logic [WIDTH_BIT-1:0] in_row,
    output logic [WIDTH_BIT-1:0] in_col,
    output logic                 in_pad,
    output logic                 win_last,
    output logic                 frame_last,
    output logic                 busy,
    output logic                 done
);

    localparam int W  = WIDTH_BIT;
    localparam int SW = WIDTH_BIT + 2;

    localparam int OUT_ROWS = out_dim(IMG_ROWS, K_ROWS, PAD, STRIDE);
    localparam int OUT_COLS = out_dim(IMG_COLS, K_COLS, PAD, STRIDE);

    localparam int MAX_DIM = max2(
        max2(max2(IMG_ROWS, IMG_COLS), max2(OUT_ROWS, OUT_COLS)),
        max2(K_ROWS, K_COLS));

    // Counter order, innermost first: k_col, k_row, out_col, out_row.
    localparam int CMAX [4] = '{
        K_COLS - 1, K_ROWS - 1, OUT_COLS - 1, OUT_ROWS - 1
    };

    if (K_ROWS > IMG_ROWS + 2 * PAD || K_COLS > IMG_COLS + 2 * PAD ||
        OUT_ROWS < 1 || OUT_COLS < 1) begin : g_bad_geom
        $error("conv_window_index_gen: kernel exceeds padded frame");
    end

    if (longint'(MAX_DIM - 1) >= (longint'(1) << WIDTH_BIT))
    begin : g_bad_width
        $error("conv_window_index_gen: WIDTH_BIT too small");
    end

    state_t state;
    state_t state_nxt;

    logic         xfer;
    logic         load;
    logic         clr_cnt;
    logic [3:0]   inc;
    logic [3:0]   wrap;
    logic [W-1:0] cnt [4];
    logic [W-1:0] nxt [4];

    logic signed [SW-1:0] r;
    logic signed [SW-1:0] c;
    logic                 pad_n;
    logic                 wl_n;
    logic                 fl_n;

    assign xfer    = out_valid && out_ready;
    assign load    = (state == IDLE) && start && !clear;
    assign clr_cnt = clear || load;

    // The final transfer does not advance, so DONE/IDLE keep the last tuple.
    assign inc = {wrap[2:0], xfer && !frame_last};

    for (genvar i = 0; i < 4; i++) begin : g_cnt
        idx_wrap_counter #(
            .MAX   (CMAX[i]),
            .WIDTH (W)
        ) u_cnt (
            .clock (clock),
            .reset (reset),
            .clr   (clr_cnt),
            .inc   (inc[i]),
            .cnt   (cnt[i]),
            .wrap  (wrap[i])
        );
    end

    assign k_col   = cnt[0];
    assign k_row   = cnt[1];
    assign out_col = cnt[2];
    assign out_row = cnt[3];

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (xfer && frame_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt == RUN);
            busy      <= (state_nxt == RUN);
            done      <= (state_nxt == DONE);
        end
    end

    // Next counter values, so the derived outputs register in step.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nxt[i] = cnt[i];
            if (clr_cnt || wrap[i]) begin
                nxt[i] = '0;
            end else if (inc[i]) begin
                nxt[i] = cnt[i] + W'(1);
            end
        end
    end

    always_comb begin
        r = SW'(nxt[3]) * SW'(STRIDE) + SW'(nxt[1]) - SW'(PAD);
        c = SW'(nxt[2]) * SW'(STRIDE) + SW'(nxt[0]) - SW'(PAD);
        pad_n = (r < 0) || (r >= SW'(IMG_ROWS)) ||
                (c < 0) || (c >= SW'(IMG_COLS));
        wl_n = (nxt[1] == W'(K_ROWS - 1)) &&
               (nxt[0] == W'(K_COLS - 1));
        fl_n = wl_n &&
               (nxt[3] == W'(OUT_ROWS - 1)) &&
               (nxt[2] == W'(OUT_COLS - 1));
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            in_row     <= '0;
            in_col     <= '0;
            in_pad     <= 1'b0;
            win_last   <= 1'b0;
            frame_last <= 1'b0;
        end else if (load || inc[0]) begin
            in_row     <= pad_n ? '0 : W'(r);
            in_col     <= pad_n ? '0 : W'(c);
            in_pad     <= pad_n;
            win_last   <= wl_n;
            frame_last <= fl_n;
        end
    end

endmodule

// File: doc/conv_window_index_gen.md
Name: conv_window_index_gen

Overview:
Parametrised successor to the matrix index counter. Sweeps a full 2-D convolution over a frame and emits one index tuple per transfer: output pixel (out_row, out_col), kernel tap (k_row, k_col), and the matching input pixel with stride and zero-padding applied. Driven by start/clear and a valid/ready output handshake. Sits between the conv controller and the image/weight buffer address logic.

Parameters:
IMG_ROWS, 4, input frame rows (>=1)
IMG_COLS, 4, input frame columns (>=1)
K_ROWS, 3, kernel rows (>=1, <= IMG_ROWS+2*PAD)
K_COLS, 3, kernel columns (>=1, <= IMG_COLS+2*PAD)
STRIDE, 1, window step in both dimensions (>=1)
PAD, 0, zero-padding border width in both dimensions (>=0)
WIDTH_BIT, 8, width of every index output; must hold max(IMG_ROWS, IMG_COLS, OUT_ROWS, OUT_COLS)-1

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a sweep; honoured only in IDLE
clear  in  1  synchronous abort to IDLE; priority over start
out_ready  in  1  consumer accepts current tuple
out_valid  out  1  tuple valid
out_row  out  WIDTH_BIT  output-pixel row
out_col  out  WIDTH_BIT  output-pixel column
k_row  out  WIDTH_BIT  kernel tap row
k_col  out  WIDTH_BIT  kernel tap column
in_row  out  WIDTH_BIT  input pixel row (0 when in_pad)
in_col  out  WIDTH_BIT  input pixel column (0 when in_pad)
in_pad  out  1  tap falls in padding; consumer uses value 0
win_last  out  1  last tap of current window (k_row=K_ROWS-1, k_col=K_COLS-1)
frame_last  out  1  last tuple of the sweep
busy  out  1  state is RUN
done  out  1  one-cycle pulse after the final transfer

Behaviour:
- Derived constants: OUT_ROWS=(IMG_ROWS+2*PAD-K_ROWS)/STRIDE+1, OUT_COLS likewise; integer division. Elaboration error if either <1 or WIDTH_BIT too small.
- Reset: state IDLE; all index outputs 0; out_valid, in_pad, win_last, frame_last, busy, done all 0.
- States: IDLE -> RUN on start (and not clear). RUN -> DONE on transfer (out_valid & out_ready) while frame_last=1. DONE -> IDLE unconditionally next cycle. Any state -> IDLE on clear.
- RUN entry: counters 0; out_valid=1 on the first RUN cycle, i.e. one cycle after start sampled. out_valid stays 1 throughout RUN.
- Loop order, innermost first: k_col, k_row, out_col, out_row. Each counter wraps to 0 at its max and carries to the next. Advance only on transfer; out_valid=1 with out_ready=0 holds every output stable.
- Input mapping, computed on WIDTH_BIT+2-bit signed: r=out_row*STRIDE+k_row-PAD, c=out_col*STRIDE+k_col-PAD. in_pad=1 if r<0, r>=IMG_ROWS, c<0 or c>=IMG_COLS; then in_row=in_col=0, else the truncated r, c.
- All outputs registered; in_row/in_col/in_pad/win_last/frame_last consistent with the counters in the same cycle.
- Total transfers per sweep: OUT_ROWS*OUT_COLS*K_ROWS*K_COLS.
- done=1 only in DONE (exactly one cycle); out_valid=0 and busy=0 there. Outputs keep last tuple in DONE/IDLE.
- start while RUN or DONE: ignored. start and clear together: clear wins, remain/return IDLE.
- clear or reset mid-sweep: next cycle IDLE, out_valid=0, counters 0; no done pulse.

Decomposition:
- Package conv_idx_pkg: state enum (IDLE, RUN, DONE); function out_dim(img, k, pad, stride).
- Sub-module idx_wrap_counter (params MAX, WIDTH; ports clock, reset, clr, inc -> cnt, wrap). Four instances chained by wrap as carry.

Test Plan:
- Defaults (4x4, 3x3, S1, P0): start pulse -> out_valid high next cycle; 36 transfers with ready=1; beat 0 in=(0,0); beat 9 out=(0,1) k=(0,0) in=(0,1); win_last on beats 8,17,26,35; frame_last+last beat 35; done one cycle later.
- PAD=1, 4x4, 3x3: OUT 4x4, 144 beats; beat 0 in_pad=1, in=(0,0); beat 4 (k=(1,1)) in=(0,0), in_pad=0.
- STRIDE=2, 5x5, 3x3: OUT 2x2; first beat with out=(0,1), k=(0,0) -> in=(0,2); out=(1,1), k=(2,2) -> in=(4,4), frame_last=1.
- Backpressure: random out_ready with 50% low -> tuple sequence identical to ready=1 run; outputs stable during stalls.
- clear on beat 10 -> next cycle IDLE, out_valid=0, no done; new start restarts at all-zero indices.
- start asserted during RUN and in DONE -> ignored, transfer count unchanged; start+clear in IDLE -> stays IDLE.
